// File: rtl/multi_player_timer.sv
// Multi-player game clock: one down-counting seconds register per player, one active at a
// time, with setup phase, pause, per-move increment on pass and sticky per-player flag-fall.
module multi_player_timer #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned SETUP_STEP  = 30,
  parameter int unsigned MOVE_INC    = 0,
  localparam int unsigned PW         = $clog2(NUM_PLAYERS),
  localparam int unsigned MIN_W      = CNT_W - 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tick_i,
  input  logic                   clear_i,
  input  logic                   setup_add_i,
  input  logic                   start_i,
  input  logic                   pause_i,
  input  logic                   pass_i,
  input  logic [PW-1:0]          sel_i,
  output logic [PW-1:0]          active_o,
  output logic                   running_o,
  output logic [NUM_PLAYERS-1:0] time_up_o,
  output logic [MIN_W-1:0]       disp_min_o,
  output logic [5:0]             disp_sec_o
);

  typedef enum logic [1:0] {StSetup, StRun, StPaused, StDone} state_e;

  localparam logic [CNT_W:0] StepExt = (CNT_W+1)'(SETUP_STEP);
  localparam logic [CNT_W:0] IncExt  = (CNT_W+1)'(MOVE_INC);
  localparam logic [PW-1:0]  LastIdx = PW'(NUM_PLAYERS - 1);
  localparam logic [PW:0]    NumExt  = (PW+1)'(NUM_PLAYERS);

  state_e                   state_q;
  logic [CNT_W-1:0]         count_q [NUM_PLAYERS];
  logic [PW-1:0]            active_q;
  logic                     running_q;
  logic [NUM_PLAYERS-1:0]   time_up_q;

  logic [CNT_W-1:0]         setup_sum [NUM_PLAYERS];
  logic [CNT_W-1:0]         act_cnt;
  logic                     act_zero;
  logic [CNT_W-1:0]         dec_cnt;
  logic [CNT_W-1:0]         pass_cnt;
  logic [PW-1:0]            next_active;
  logic                     sel_ok;
  logic [CNT_W-1:0]         sel_cnt;

  // Saturating add; the carry bit flags overflow of the CNT_W-bit counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W:0]   b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + b;
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Next-value datapath shared by the FSM, plus the combinational mm:ss display.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      setup_sum[i] = sat_add(count_q[i], StepExt);
    end
    act_cnt     = count_q[active_q];
    act_zero    = (act_cnt == '0);
    // Only used when the active count is non-zero or tick is low, so it cannot wrap.
    dec_cnt     = act_cnt - CNT_W'(tick_i);
    pass_cnt    = sat_add(dec_cnt, IncExt);
    next_active = (active_q == LastIdx) ? '0 : active_q + 1'b1;
    sel_ok      = ({1'b0, sel_i} < NumExt);
    sel_cnt     = sel_ok ? count_q[sel_i] : '0;
    disp_min_o  = MIN_W'(sel_cnt / CNT_W'(60));
    disp_sec_o  = 6'(sel_cnt % CNT_W'(60));
  end

  // Game FSM with all counters, active index and flags registered together.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q   <= StSetup;
      active_q  <= '0;
      running_q <= 1'b0;
      time_up_q <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StSetup: begin
          if (setup_add_i) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              count_q[i] <= setup_sum[i];
            end
          end
          if (start_i) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (tick_i && act_zero) begin
            // Flag-fall ends the game; any pass or pause this cycle is dropped.
            time_up_q[active_q] <= 1'b1;
            state_q             <= StDone;
            running_q           <= 1'b0;
          end else begin
            if (pass_i) begin
              count_q[active_q] <= pass_cnt;
              active_q          <= next_active;
            end else if (tick_i) begin
              count_q[active_q] <= dec_cnt;
            end
            if (pause_i) begin
              state_q   <= StPaused;
              running_q <= 1'b0;
            end
          end
        end
        StPaused: begin
          if (start_i) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StDone: begin
        end
        default: begin
          state_q   <= StSetup;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign active_o  = active_q;
  assign running_o = running_q;
  assign time_up_o = time_up_q;

endmodule

// File: tb/tb_multi_player_timer.sv
// Directed bench for multi_player_timer (2 players, 12-bit counters, 30 s setup step,
// 5 s move increment).
module tb_multi_player_timer;

  logic       clk = 1'b0;
  logic       rst, tick, clear, setup_add, start, pause, pass;
  logic [0:0] sel;
  logic [0:0] active;
  logic       running;
  logic [1:0] time_up;
  logic [6:0] disp_min;
  logic [5:0] disp_sec;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  multi_player_timer #(
    .NUM_PLAYERS(2),
    .CNT_W      (12),
    .SETUP_STEP (30),
    .MOVE_INC   (5)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tick_i     (tick),
    .clear_i    (clear),
    .setup_add_i(setup_add),
    .start_i    (start),
    .pause_i    (pause),
    .pass_i     (pass),
    .sel_i      (sel),
    .active_o   (active),
    .running_o  (running),
    .time_up_o  (time_up),
    .disp_min_o (disp_min),
    .disp_sec_o (disp_sec)
  );

  // Drive one cycle of inputs, clock it in, release all strobes, sample 1 ns after edge.
  task automatic step(input logic t, input logic a, input logic s, input logic p,
                      input logic ps, input logic c);
    tick = t; setup_add = a; start = s; pause = p; pass = ps; clear = c;
    @(posedge clk);
    #1;
    tick = 0; setup_add = 0; start = 0; pause = 0; pass = 0; clear = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  // Reads a channel's count back through the display path.
  task automatic get_cnt(input logic ch, output int c);
    sel = ch;
    #1;
    c = int'(disp_min) * 60 + int'(disp_sec);
  endtask

  task automatic test_reset();
    int c;
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    n_total++; if (running !== 1'b0) $display("FAIL reset_running got %0d want 0", running);
    else n_pass++;
    n_total++; if (active !== 1'b0) $display("FAIL reset_active got %0d want 0", active);
    else n_pass++;
    n_total++; if (time_up !== 2'b00) $display("FAIL reset_time_up got %b want 00", time_up);
    else n_pass++;
    get_cnt(0, c);
    n_total++; if (c !== 0) $display("FAIL reset_cnt0 got %0d want 0", c); else n_pass++;
    get_cnt(1, c);
    n_total++; if (c !== 0) $display("FAIL reset_cnt1 got %0d want 0", c); else n_pass++;
  endtask

  task automatic test_setup();
    int c;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
    ticks(1);  // ignored in setup
    sel = 0; #1;
    n_total++; if (disp_min !== 7'd5) $display("FAIL setup_min got %0d want 5", disp_min);
    else n_pass++;
    n_total++; if (disp_sec !== 6'd0) $display("FAIL setup_sec got %0d want 0", disp_sec);
    else n_pass++;
    get_cnt(1, c);
    n_total++; if (c !== 300) $display("FAIL setup_cnt1 got %0d want 300", c); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL setup_running got %0d want 0", running);
    else n_pass++;
  endtask

  task automatic test_run();
    int c;
    step(0, 0, 1, 0, 0, 0);
    n_total++; if (running !== 1'b1) $display("FAIL run_running got %0d want 1", running);
    else n_pass++;
    ticks(61);
    sel = 0; #1;
    n_total++; if (disp_min !== 7'd3 || disp_sec !== 6'd59)
      $display("FAIL run_disp got %0d:%0d want 3:59", disp_min, disp_sec);
    else n_pass++;
    get_cnt(1, c);
    n_total++; if (c !== 300) $display("FAIL run_cnt1 got %0d want 300", c); else n_pass++;
    n_total++; if (active !== 1'b0) $display("FAIL run_active got %0d want 0", active);
    else n_pass++;
  endtask

  task automatic test_pass_inc();
    int c;
    ticks(229);
    get_cnt(0, c);
    n_total++; if (c !== 10) $display("FAIL pre_pass_cnt0 got %0d want 10", c); else n_pass++;
    step(1, 0, 0, 0, 1, 0);  // pass with tick: 10 - 1 + 5
    get_cnt(0, c);
    n_total++; if (c !== 14) $display("FAIL pass_cnt0 got %0d want 14", c); else n_pass++;
    n_total++; if (active !== 1'b1) $display("FAIL pass_active got %0d want 1", active);
    else n_pass++;
    get_cnt(1, c);
    n_total++; if (c !== 300) $display("FAIL pass_cnt1 got %0d want 300", c); else n_pass++;
  endtask

  task automatic test_pause();
    int c;
    step(0, 0, 0, 1, 0, 0);
    n_total++; if (running !== 1'b0) $display("FAIL pause_running got %0d want 0", running);
    else n_pass++;
    ticks(5);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    get_cnt(1, c);
    n_total++; if (c !== 300) $display("FAIL pause_cnt1 got %0d want 300", c); else n_pass++;
    n_total++; if (active !== 1'b1) $display("FAIL pause_active got %0d want 1", active);
    else n_pass++;
    step(0, 0, 1, 0, 0, 0);
    ticks(1);
    get_cnt(1, c);
    n_total++; if (c !== 299) $display("FAIL resume_cnt1 got %0d want 299", c); else n_pass++;
    step(1, 0, 0, 1, 0, 0);  // tick still lands in the pausing cycle
    get_cnt(1, c);
    n_total++; if (c !== 298) $display("FAIL pause_tick_cnt1 got %0d want 298", c);
    else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL pause_tick_running got %0d want 0", running);
    else n_pass++;
    step(0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_time_up();
    int c;
    ticks(298);
    get_cnt(1, c);
    n_total++; if (c !== 0) $display("FAIL zero_cnt1 got %0d want 0", c); else n_pass++;
    n_total++; if (time_up !== 2'b00) $display("FAIL zero_time_up got %b want 00", time_up);
    else n_pass++;
    step(1, 0, 0, 0, 1, 0);  // flag-fall; the pass is dropped
    n_total++; if (time_up !== 2'b10) $display("FAIL flag_time_up got %b want 10", time_up);
    else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL flag_running got %0d want 0", running);
    else n_pass++;
    step(1, 1, 1, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    n_total++; if (time_up !== 2'b10) $display("FAIL done_time_up got %b want 10", time_up);
    else n_pass++;
    n_total++; if (active !== 1'b1) $display("FAIL done_active got %0d want 1", active);
    else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL done_running got %0d want 0", running);
    else n_pass++;
    get_cnt(0, c);
    n_total++; if (c !== 14) $display("FAIL done_cnt0 got %0d want 14", c); else n_pass++;
    get_cnt(1, c);
    n_total++; if (c !== 0) $display("FAIL done_cnt1 got %0d want 0", c); else n_pass++;
  endtask

  task automatic test_saturate();
    int c;
    step(0, 0, 0, 0, 0, 1);
    n_total++; if (time_up !== 2'b00) $display("FAIL clr_time_up got %b want 00", time_up);
    else n_pass++;
    n_total++; if (active !== 1'b0) $display("FAIL clr_active got %0d want 0", active);
    else n_pass++;
    for (int i = 0; i < 136; i++) step(0, 1, 0, 0, 0, 0);
    get_cnt(1, c);
    n_total++; if (c !== 4080) $display("FAIL sat_pre got %0d want 4080", c); else n_pass++;
    step(0, 1, 0, 0, 0, 0);
    sel = 0; #1;
    n_total++; if (disp_min !== 7'd68 || disp_sec !== 6'd15)
      $display("FAIL sat_disp got %0d:%0d want 68:15", disp_min, disp_sec);
    else n_pass++;
    step(0, 1, 0, 0, 0, 0);
    get_cnt(1, c);
    n_total++; if (c !== 4095) $display("FAIL sat_hold got %0d want 4095", c); else n_pass++;
  endtask

  task automatic test_clear_mid_run();
    int c;
    step(0, 0, 1, 0, 0, 0);
    ticks(1);
    get_cnt(0, c);
    n_total++; if (c !== 4094) $display("FAIL cmr_tick got %0d want 4094", c); else n_pass++;
    step(0, 0, 0, 0, 1, 0);  // 4094 + 5 saturates
    get_cnt(0, c);
    n_total++; if (c !== 4095) $display("FAIL cmr_pass_sat got %0d want 4095", c); else n_pass++;
    n_total++; if (active !== 1'b1) $display("FAIL cmr_active got %0d want 1", active);
    else n_pass++;
    step(1, 0, 0, 0, 0, 1);
    n_total++; if (running !== 1'b0 || active !== 1'b0)
      $display("FAIL cmr_clear got run=%0d act=%0d want 0/0", running, active);
    else n_pass++;
    get_cnt(0, c);
    n_total++; if (c !== 0) $display("FAIL cmr_cnt0 got %0d want 0", c); else n_pass++;
    get_cnt(1, c);
    n_total++; if (c !== 0) $display("FAIL cmr_cnt1 got %0d want 0", c); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c;
    step(0, 1, 1, 0, 0, 0);  // add then run
    get_cnt(1, c);
    n_total++; if (c !== 30) $display("FAIL b2b_add got %0d want 30", c); else n_pass++;
    n_total++; if (running !== 1'b1) $display("FAIL b2b_run got %0d want 1", running);
    else n_pass++;
    step(0, 0, 1, 1, 0, 0);  // pause wins over start
    n_total++; if (running !== 1'b0) $display("FAIL b2b_pause got %0d want 0", running);
    else n_pass++;
  endtask

  initial begin
    rst = 0; tick = 0; clear = 0; setup_add = 0; start = 0; pause = 0; pass = 0; sel = 0;
    @(negedge clk);
    test_reset();
    test_setup();
    test_run();
    test_pass_inc();
    test_pause();
    test_time_up();
    test_saturate();
    test_clear_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
